// File: rtl/bus_arbiter_pkg.sv
// rtl/bus_arbiter_pkg.sv - shared constants, FSM encodings and helpers for bus_arbiter
package bus_arbiter_pkg;
  localparam int N_MASTERS        = 3;
  localparam int N_SLAVES         = 4;
  localparam int MIDX_W           = 2;
  localparam int MAX_HOLD_DEFAULT = 16;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_OWN  = 1'b1;

  function automatic logic [MIDX_W-1:0] onehot_to_idx(input logic [N_MASTERS-1:0] oh);
    logic [MIDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (oh[i]) idx = MIDX_W'(i);
    end
    return idx;
  endfunction
endpackage

// File: rtl/bus_arb_picker.sv
// rtl/bus_arb_picker.sv - combinational rotating picker; ptr names the master searched first
module bus_arb_picker
  import bus_arbiter_pkg::*;
(
  input  logic [N_MASTERS-1:0] req,
  input  logic [MIDX_W-1:0]    ptr,
  output logic [N_MASTERS-1:0] winner
);

  logic [MIDX_W-1:0] cand;

  always_comb begin
    winner = '0;
    cand   = '0;
    for (int k = 0; k < N_MASTERS; k++) begin
      cand = MIDX_W'((int'(ptr) + k) % N_MASTERS);
      if (winner == '0 && req[cand]) winner[cand] = 1'b1;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - 3-master / 4-slave bus arbiter with hold limit and address decode
// BUS_ARB_ROUND_ROBIN_EN selects round-robin arbitration instead of fixed priority m0 > m1 > m2.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int MAX_HOLD     = MAX_HOLD_DEFAULT,
  parameter int SLV_BASE_BIT = 28
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   m_req_in,
  input  logic [95:0]  m_addr_in,
  input  logic [95:0]  m_data_in,
  input  logic [2:0]   m_rw_in,
  output logic [2:0]   m_grant_out,
  output logic [31:0]  m_data_out,
  output logic [31:0]  s_addr_out,
  output logic [31:0]  s_data_out,
  output logic         s_rw_out,
  output logic [3:0]   s_sel_out,
  input  logic [127:0] s_data_in,
  output logic         hold_flag_out,
  output logic         dec_err_out
);

  localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  logic [0:0]           state;
  logic [HOLD_W-1:0]    hold_cnt;
  logic                 first_own;
  logic [N_MASTERS-1:0] winner;
  logic [MIDX_W-1:0]    ptr;
  logic                 owner_req;
  logic                 others_req;
  logic [3:0]           slv_idx;
  logic                 slv_ok;

`ifdef BUS_ARB_ROUND_ROBIN_EN
  // Search starts just past the most recent winner.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr <= '0;
    end else if (state == ST_IDLE && |m_req_in) begin
      ptr <= (onehot_to_idx(winner) == MIDX_W'(N_MASTERS - 1)) ? '0
                                                               : onehot_to_idx(winner) + 1'b1;
    end
  end
`else
  assign ptr = '0;
`endif

  bus_arb_picker u_picker (
    .req    (m_req_in),
    .ptr    (ptr),
    .winner (winner)
  );

  assign owner_req  = |(m_req_in & m_grant_out);
  assign others_req = |(m_req_in & ~m_grant_out);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_IDLE;
      m_grant_out <= '0;
      hold_cnt    <= '0;
      first_own   <= 1'b0;
    end else begin
      first_own <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|m_req_in) begin
            state       <= ST_OWN;
            m_grant_out <= winner;
            hold_cnt    <= '0;
            first_own   <= 1'b1;
          end
        end
        default: begin
          // Release on owner drop or when contention has lasted MAX_HOLD cycles.
          if (!owner_req || (others_req && hold_cnt == HOLD_LAST)) begin
            state       <= ST_IDLE;
            m_grant_out <= '0;
            hold_cnt    <= '0;
          end else if (others_req) begin
            hold_cnt <= hold_cnt + 1'b1;
          end else begin
            hold_cnt <= '0;
          end
        end
      endcase
    end
  end

  always_comb begin
    s_addr_out = '0;
    s_data_out = '0;
    s_rw_out   = 1'b0;
    case (m_grant_out)
      3'b001: begin
        s_addr_out = m_addr_in[31:0];
        s_data_out = m_data_in[31:0];
        s_rw_out   = m_rw_in[0];
      end
      3'b010: begin
        s_addr_out = m_addr_in[63:32];
        s_data_out = m_data_in[63:32];
        s_rw_out   = m_rw_in[1];
      end
      3'b100: begin
        s_addr_out = m_addr_in[95:64];
        s_data_out = m_data_in[95:64];
        s_rw_out   = m_rw_in[2];
      end
      default: ;
    endcase
  end

  assign slv_idx = s_addr_out[SLV_BASE_BIT+3 -: 4];
  assign slv_ok  = (|m_grant_out) && (slv_idx < 4'(N_SLAVES));

  always_comb begin
    s_sel_out  = '0;
    m_data_out = '0;
    if (slv_ok) begin
      s_sel_out[slv_idx[1:0]] = 1'b1;
      case (slv_idx[1:0])
        2'd0:    m_data_out = s_data_in[31:0];
        2'd1:    m_data_out = s_data_in[63:32];
        2'd2:    m_data_out = s_data_in[95:64];
        default: m_data_out = s_data_in[127:96];
      endcase
    end
  end

  assign dec_err_out   = first_own & ~slv_ok;
  assign hold_flag_out = (m_req_in[1] | m_req_in[2]) & ~(m_grant_out[1] | m_grant_out[2]);

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - randomized bench with behavioural model for bus_arbiter
module tb_bus_arbiter;
  localparam int MAX_HOLD = 16;
  localparam int SB       = 28;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   m_req_in;
  logic [95:0]  m_addr_in;
  logic [95:0]  m_data_in;
  logic [2:0]   m_rw_in;
  logic [2:0]   m_grant_out;
  logic [31:0]  m_data_out;
  logic [31:0]  s_addr_out;
  logic [31:0]  s_data_out;
  logic         s_rw_out;
  logic [3:0]   s_sel_out;
  logic [127:0] s_data_in;
  logic         hold_flag_out;
  logic         dec_err_out;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  int mdl_owner = -1;
  int mdl_cnt   = 0;
  int mdl_rr    = 0;
  bit mdl_fresh = 1'b0;

  logic [2:0]  e_grant;
  logic [31:0] e_addr, e_wd, e_rd;
  logic        e_rw, e_hold, e_dec;
  logic [3:0]  e_sel;
  int          e_idx;
  int          k;

  bus_arbiter #(.MAX_HOLD(MAX_HOLD), .SLV_BASE_BIT(SB)) dut (
    .clk           (clk),
    .rst           (rst),
    .m_req_in      (m_req_in),
    .m_addr_in     (m_addr_in),
    .m_data_in     (m_data_in),
    .m_rw_in       (m_rw_in),
    .m_grant_out   (m_grant_out),
    .m_data_out    (m_data_out),
    .s_addr_out    (s_addr_out),
    .s_data_out    (s_data_out),
    .s_rw_out      (s_rw_out),
    .s_sel_out     (s_sel_out),
    .s_data_in     (s_data_in),
    .hold_flag_out (hold_flag_out),
    .dec_err_out   (dec_err_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input logic [2:0] req, input int rr);
    int c;
`ifdef BUS_ARB_ROUND_ROBIN_EN
    for (int j = 0; j < 3; j++) begin
      c = (rr + j) % 3;
      if (req[c]) return c;
    end
`else
    c = rr;
    for (int j = 0; j < 3; j++) begin
      if (req[j]) return j;
    end
`endif
    return -1;
  endfunction

  task automatic mdl_step();
    if (rst === 1'b0) begin
      mdl_owner = -1;
      mdl_cnt   = 0;
      mdl_rr    = 0;
      mdl_fresh = 1'b0;
    end else if (mdl_owner < 0) begin
      mdl_fresh = 1'b0;
      if (m_req_in != 3'b000) begin
        mdl_owner = pick(m_req_in, mdl_rr);
        mdl_cnt   = 0;
        mdl_fresh = 1'b1;
        mdl_rr    = (mdl_owner + 1) % 3;
      end
    end else begin
      mdl_fresh = 1'b0;
      if (!m_req_in[mdl_owner]) begin
        mdl_owner = -1;
        mdl_cnt   = 0;
      end else if ((m_req_in & ~(3'b001 << mdl_owner)) != 3'b000) begin
        mdl_cnt++;
        if (mdl_cnt == MAX_HOLD) begin
          mdl_owner = -1;
          mdl_cnt   = 0;
        end
      end else begin
        mdl_cnt = 0;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    mdl_step();
  end

  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      e_grant = (mdl_owner < 0) ? 3'b000 : 3'(1 << mdl_owner);
      if (mdl_owner >= 0) begin
        e_addr = m_addr_in[32*mdl_owner +: 32];
        e_wd   = m_data_in[32*mdl_owner +: 32];
        e_rw   = m_rw_in[mdl_owner];
      end else begin
        e_addr = '0;
        e_wd   = '0;
        e_rw   = 1'b0;
      end
      e_idx = int'((e_addr >> SB) & 32'hF);
      if (mdl_owner >= 0 && e_idx < 4) begin
        e_sel = 4'(1 << e_idx);
        e_rd  = s_data_in[32*e_idx +: 32];
      end else begin
        e_sel = 4'b0000;
        e_rd  = '0;
      end
      e_hold = (m_req_in[1] | m_req_in[2]) & ~(e_grant[1] | e_grant[2]);
      e_dec  = mdl_fresh && (mdl_owner >= 0) && (e_idx >= 4);
      chk("cmp_grant", 32'(m_grant_out), 32'(e_grant));
      chk("cmp_s_addr", s_addr_out, e_addr);
      chk("cmp_s_data", s_data_out, e_wd);
      chk("cmp_s_rw", 32'(s_rw_out), 32'(e_rw));
      chk("cmp_s_sel", 32'(s_sel_out), 32'(e_sel));
      chk("cmp_m_data", m_data_out, e_rd);
      chk("cmp_hold_flag", 32'(hold_flag_out), 32'(e_hold));
      chk("cmp_dec_err", 32'(dec_err_out), 32'(e_dec));
    end
  end

  initial begin
    rst       = 1'b0;
    m_req_in  = 3'b000;
    m_addr_in = '0;
    m_data_in = '0;
    m_rw_in   = 3'b000;
    s_data_in = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0F0F_0F0F};
    step();
    step();
    cmp_en = 1'b1;
    @(negedge clk);
    chk("rst_grant", 32'(m_grant_out), 32'h0);
    chk("rst_dec_err", 32'(dec_err_out), 32'h0);
    chk("rst_s_sel", 32'(s_sel_out), 32'h0);
    chk("rst_s_addr", s_addr_out, 32'h0);

    // request to grant latency, hold flag and slave-2 decode
    step();
    rst = 1'b1;
    m_addr_in[63:32]  = 32'h2000_0010;
    m_addr_in[95:64]  = 32'h1000_0000;
    s_data_in[95:64]  = 32'hDEAD_BEEF;
    m_req_in = 3'b110;
    @(negedge clk);
    chk("req_grant_pending", 32'(m_grant_out), 32'h0);
    chk("req_hold_flag_pre", 32'(hold_flag_out), 32'h1);
    step();
    @(negedge clk);
    chk("req_grant_m1", 32'(m_grant_out), 32'h2);
    chk("req_hold_flag_post", 32'(hold_flag_out), 32'h0);
    chk("dec_s_sel_slave2", 32'(s_sel_out), 32'h4);
    chk("dec_m_data_slave2", m_data_out, 32'hDEAD_BEEF);
    chk("dec_s_addr", s_addr_out, 32'h2000_0010);
    m_req_in = 3'b000;
    step();
    step();

    // hold limit: m1 owns while m0 requests continuously
    m_req_in = 3'b010;
    step();
    m_req_in = 3'b011;
    for (int i = 0; i < MAX_HOLD; i++) begin
      @(negedge clk);
      chk("hold_m1_kept", 32'(m_grant_out), 32'h2);
      step();
    end
    @(negedge clk);
    chk("hold_release_idle", 32'(m_grant_out), 32'h0);
    step();
    @(negedge clk);
    chk("hold_regrant_m0", 32'(m_grant_out), 32'h1);
    m_req_in = 3'b000;
    step();
    step();

    // undecoded address
    m_addr_in[31:0] = 32'h7000_0000;
    m_req_in = 3'b001;
    @(negedge clk);
    chk("decerr_before_grant", 32'(dec_err_out), 32'h0);
    step();
    @(negedge clk);
    chk("decerr_pulse", 32'(dec_err_out), 32'h1);
    chk("decerr_s_sel", 32'(s_sel_out), 32'h0);
    chk("decerr_m_data", m_data_out, 32'h0);
    step();
    @(negedge clk);
    chk("decerr_one_cycle", 32'(dec_err_out), 32'h0);
    chk("decerr_still_owned", 32'(m_grant_out), 32'h1);
    m_req_in = 3'b000;
    step();
    step();

    // reset while m2 owns
    m_req_in = 3'b100;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_m2_owns", 32'(m_grant_out), 32'h4);
    step();
    @(negedge clk);
    chk("rstmid_grant_dropped", 32'(m_grant_out), 32'h0);
    rst = 1'b1;
    step();
    @(negedge clk);
    chk("rstmid_regrant", 32'(m_grant_out), 32'h4);
    m_req_in = 3'b000;
    step();
    step();

`ifdef BUS_ARB_ROUND_ROBIN_EN
    rst = 1'b0;
    step();
    rst = 1'b1;
    m_req_in = 3'b111;
    step();
    @(negedge clk);
    chk("rr_first_m0", 32'(m_grant_out), 32'h1);
    m_req_in = 3'b110;
    step();
    step();
    @(negedge clk);
    chk("rr_second_m1", 32'(m_grant_out), 32'h2);
    m_req_in = 3'b101;
    step();
    step();
    @(negedge clk);
    chk("rr_third_m2", 32'(m_grant_out), 32'h4);
    m_req_in = 3'b011;
    step();
    step();
    @(negedge clk);
    chk("rr_fourth_m0", 32'(m_grant_out), 32'h1);
    m_req_in = 3'b000;
    step();
    step();
`endif

    for (int i = 0; i < 3000; i++) begin
      step();
      for (int b = 0; b < 3; b++) begin
        if ($urandom_range(0, 19) == 0) m_req_in[b] = ~m_req_in[b];
      end
      if ($urandom_range(0, 7) == 0) begin
        k = $urandom_range(0, 2);
        m_addr_in[32*k +: 32] = {4'($urandom_range(0, 7)), 28'($urandom)};
      end
      m_data_in = {$urandom, $urandom, $urandom};
      m_rw_in   = 3'($urandom);
      s_data_in = {$urandom, $urandom, $urandom, $urandom};
      rst       = ($urandom_range(0, 199) != 0);
    end
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 16: maximum consecutive cycles one master keeps the grant while another master is requesting.
REQ-002 Parameter SLV_BASE_BIT, default 28: lowest bit of the 4-bit slave-select field in the address.
REQ-003 Clock and reset are decided: one clock; reset is synchronous and active-low.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst  in  1  synchronous, active-low reset.
REQ-006 m_req_in  in  3  per-master bus request; m0 = debug/DMA, m1 = core data port, m2 = core fetch port.
REQ-007 m_addr_in  in  96  per-master address, master k at bits [32k+31:32k].
REQ-008 m_data_in  in  96  per-master write data, same packing as m_addr_in.
REQ-009 m_rw_in  in  3  per-master access type: 1 = write, 0 = read.
REQ-010 m_grant_out  out  3  one-hot registered grant; all zero when no master owns the bus.
REQ-011 m_data_out  out  32  read data from the selected slave, shared by all masters.
REQ-012 s_addr_out, s_data_out  out  32 each  granted master's address and write data.
REQ-013 s_rw_out  out  1  granted master's m_rw_in.
REQ-014 s_sel_out  out  4  one-hot slave select.
REQ-015 s_data_in  in  128  slave k read data at bits [32k+31:32k].
REQ-016 hold_flag_out  out  1  pipeline hold request to the core controller.
REQ-017 dec_err_out  out  1  one-cycle pulse when a granted access decodes to no slave.

Function
REQ-018 FSM states are IDLE and OWN.
REQ-019 In IDLE, when any m_req_in bit is high, the arbiter picks a winner and registers it: m_grant_out is one-hot on the next edge and the FSM moves to OWN, giving 1 cycle from request to grant.
REQ-020 Default pick order is fixed priority m0 > m1 > m2.
REQ-021 In OWN, the grant holds while the owner's m_req_in stays high.
REQ-022 When the owner's m_req_in is low, the next edge clears the grant and enters IDLE, leaving one dead cycle before re-arbitration.
REQ-023 In OWN, hold_cnt increments each cycle that another master requests and clears when none does.
REQ-024 When hold_cnt reaches MAX_HOLD-1 with another master requesting, the next edge forces release to IDLE.
REQ-025 hold_cnt clears on every grant change.
REQ-026 Slave index is addr[SLV_BASE_BIT+3:SLV_BASE_BIT].
REQ-027 Index 0-3 drives one-hot s_sel_out combinationally from the granted address.
REQ-028 Index 4-15 drives s_sel_out = 0, m_data_out = 0, and a 1-cycle dec_err_out pulse on the first OWN cycle.
REQ-029 With no grant, s_sel_out = 0, s_rw_out = 0, and s_addr_out = s_data_out = 0.
REQ-030 m_data_out equals s_data_in of the selected slave, combinationally, in the same cycle.
REQ-031 hold_flag_out = (m_req_in[1] | m_req_in[2]) & ~(m_grant_out[1] | m_grant_out[2]).
REQ-032 A request withdrawn before grant is dropped with no grant issued.
REQ-033 A request arriving in the same cycle as a release waits for the IDLE cycle.

Reset
REQ-034 On rst low at a clock edge, the FSM goes to IDLE, m_grant_out = 0, hold_cnt = 0, dec_err_out = 0, and round-robin pointer = m0.
REQ-035 Reset mid-transaction drops the grant immediately; the access is not completed.

Configuration
REQ-036 Macro BUS_ARB_ROUND_ROBIN_EN defined: IDLE picks the first requester after the last owner in cyclic order m0->m1->m2->m0; the pointer updates on each grant.
REQ-037 Macro absent: fixed priority per REQ-020 and no pointer register.

Structure
REQ-038 The shared defines file holds master count (3), slave count (4), state encodings, and the MAX_HOLD default.
REQ-039 Sub-module bus_arb_picker is a combinational priority/rotating picker taking a request vector and pointer and returning a one-hot winner; it is instantiated once.

Verification
REQ-040 m_req_in = 3'b110 in IDLE -> m_grant_out = 3'b010 one cycle later; hold_flag_out = 1 until the grant, then 0.
REQ-041 m1 owns; m0 requests continuously; MAX_HOLD = 16 -> grant drops after 16 contended cycles, one IDLE cycle follows, then m_grant_out = 3'b001.
REQ-042 Granted address 0x2000_0010, s_data_in slave2 = 0xDEAD_BEEF -> s_sel_out = 4'b0100 and m_data_out = 0xDEAD_BEEF in the same cycle.
REQ-043 Granted address 0x7000_0000 -> s_sel_out = 0, m_data_out = 0, dec_err_out high for exactly 1 cycle.
REQ-044 With BUS_ARB_ROUND_ROBIN_EN, all three requesting with 1-cycle requests -> grant order m0, m1, m2, m0.
REQ-045 rst low while m2 owns -> next edge m_grant_out = 0 and FSM in IDLE; a request asserted after reset is granted 1 cycle later.
